matrix_row_driver: RTL

//  Row-side companion of the 5-column ring-counter scan for the LED matrix.
//  - Accepts a one-hot column vector and drives the row pattern for the active column.
//  - Patterns come from a double-buffered frame store of 3 mirrored column slots.
//  - A writer loads a new image into the shadow buffer through a valid/ready handshake.
//  - The shadow buffer is promoted to the front buffer only at the frame boundary, so no tearing.

---
 rtl/matrix_row_driver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/matrix_row_driver.sv
// matrix_row_driver
//   Row-side companion of a 5-column ring-counter LED matrix scan. Drives the
//   row pattern for the active column from a double-buffered frame store of
//   three mirrored column slots (cols 4/0, 3/1, 2). A writer fills the shadow
//   buffer over a valid/ready handshake; the shadow is promoted to the front
//   buffer only when the scan passes the last column, so no frame tears.
//
// Ports
//   clock     in   1     system clock, rising edge
//   reset     in   1     synchronous, active-high reset
//   col       in   5     one-hot active column, 5'b10000 = first column
//   wr_valid  in   1     writer presents a column pattern
//   wr_ready  out  1     pattern accepted this cycle when wr_valid is high
//   wr_col    in   2     target slot (0: cols 4/0, 1: cols 3/1, 2: col 2, 3: illegal)
//   wr_data   in   ROWS  pattern, bit r = 1 lights row r
//   wr_last   in   1     final write of an image, arms the buffer swap
//   row       out  ROWS  row drive for the active column
//   swapped   out  1     one-cycle pulse, new image became visible
//   wr_err    out  1     one-cycle pulse, accepted write targeted slot 3
//   col_error out  1     col is not exactly one-hot
module matrix_row_driver #(
  parameter int ROWS       = 7,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      col,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [1:0]      wr_col,
  input  logic [ROWS-1:0] wr_data,
  input  logic            wr_last,
  output logic [ROWS-1:0] row,
  output logic            swapped,
  output logic            wr_err,
  output logic            col_error
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [ROWS-1:0] ROW_OFF = ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};
  localparam logic [4:0]      COL_LAST = 5'b00001;

  state_t          state_r;
  state_t          state_next_s;
  logic [ROWS-1:0] front_r  [3];
  logic [ROWS-1:0] shadow_r [3];
  logic            swapped_r;
  logic            wr_err_r;
  logic            handshake_s;
  logic            swap_s;
  logic            col_error_s;
  logic [ROWS-1:0] pattern_s;

  // True when exactly one of the five column bits is set.
  function automatic logic is_one_hot5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'd0, v[i]};
    end
    return (n == 3'd1);
  endfunction

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a wr_last handshake arms the swap, the last column fires it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s && wr_last) begin
          state_next_s = PENDING;
        end else begin
          state_next_s = IDLE;
        end
      end
      PENDING: begin
        if (col == COL_LAST) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = PENDING;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: writes are only accepted in IDLE and never while reset is held.
  always_comb begin
    if ((state_r == IDLE) && !reset) begin
      wr_ready = 1'b1;
    end else begin
      wr_ready = 1'b0;
    end
    handshake_s = wr_valid && wr_ready;
    // Exact match on the last column; a malformed col never promotes the image.
    swap_s = (state_r == PENDING) && (col == COL_LAST);
  end

  // Frame store: promote shadow on swap, load shadow on a legal handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        front_r[i]  <= {ROWS{1'b0}};
        shadow_r[i] <= {ROWS{1'b0}};
      end
    end else begin
      if (swap_s) begin
        for (int i = 0; i < 3; i++) begin
          front_r[i] <= shadow_r[i];
        end
      end
      // Swap and handshake are exclusive since wr_ready is low in PENDING.
      if (handshake_s) begin
        case (wr_col)
          2'd0:    shadow_r[0] <= wr_data;
          2'd1:    shadow_r[1] <= wr_data;
          2'd2:    shadow_r[2] <= wr_data;
          default: ; // slot 3 is illegal: handshake completes, nothing stored
        endcase
      end
    end
  end

  // Status pulses, one cycle after the triggering edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      swapped_r <= 1'b0;
      wr_err_r  <= 1'b0;
    end else begin
      swapped_r <= swap_s;
      wr_err_r  <= handshake_s && (wr_col == 2'd3);
    end
  end

  assign swapped = swapped_r;
  assign wr_err  = wr_err_r;

  // Mirrored slot decode: columns 4/0 and 3/1 share a pattern.
  always_comb begin
    col_error_s = !is_one_hot5(col);
    case (col)
      5'b10000, 5'b00001: pattern_s = front_r[0];
      5'b01000, 5'b00010: pattern_s = front_r[1];
      5'b00100:           pattern_s = front_r[2];
      default:            pattern_s = {ROWS{1'b0}};
    endcase
  end

  // Row drive, zero latency from col; blanked during reset or on a bad column.
  always_comb begin
    if (reset || col_error_s) begin
      row = ROW_OFF;
    end else if (ACTIVE_LOW) begin
      row = ~pattern_s;
    end else begin
      row = pattern_s;
    end
  end

  assign col_error = col_error_s;

endmodule
